// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg
// Definitions shared by the pipeline stages of the 5-stage MIPS core:
//   - forwarding-select encodings, also reported on the fwd_a/fwd_b debug ports
//   - the architectural zero register number
//   - the layout of the ID/EX pipeline register, without the opaque control
//     bundle, whose width is a module parameter
package mips_pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;  // operand comes from the latched RF read
  localparam logic [1:0] FWD_EXM = 2'd1;  // operand comes from the EX/MEM result
  localparam logic [1:0] FWD_WB  = 2'd2;  // operand comes from the MEM/WB write data

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Fields of the ID/EX register. An all-zero value is a bubble.
  typedef struct packed {
    logic        valid;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [4:0]  waddr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [31:0] pc4;
  } id_ex_t;

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit
// Forwarding select and mux for one EX operand. This block is purely
// combinational.
// Ports:
//   src_reg       in  5   register number the EX instruction reads
//   rf_data       in  32  value latched from the register file in ID
//   exm_reg_write in  1   EX/MEM instruction writes a register
//   exm_waddr     in  5   EX/MEM destination register
//   exm_result    in  32  EX/MEM result
//   wb_reg_write  in  1   MEM/WB instruction writes a register
//   wb_waddr      in  5   MEM/WB destination register
//   wb_wdata      in  32  MEM/WB write data
//   sel           out 2   FWD_RF / FWD_EXM / FWD_WB
//   operand       out 32  final operand for the ALU
module fwd_unit
  import mips_pipe_pkg::*;
(
  input  logic [4:0]  src_reg,
  input  logic [31:0] rf_data,
  input  logic        exm_reg_write,
  input  logic [4:0]  exm_waddr,
  input  logic [31:0] exm_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  output logic [1:0]  sel,
  output logic [31:0] operand
);

  logic hit_exm;
  logic hit_wb;

  // $0 is hard-wired to zero, so a write targeting it must never be forwarded.
  assign hit_exm = exm_reg_write && (exm_waddr != REG_ZERO) && (exm_waddr == src_reg);
  assign hit_wb  = wb_reg_write  && (wb_waddr  != REG_ZERO) && (wb_waddr  == src_reg);

  // EX/MEM is checked first: it holds the younger, and therefore newer, value.
  // NOTE: every output gets a default at the top of always_comb so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    sel     = FWD_RF;
    operand = rf_data;
    if (hit_exm) begin
      sel     = FWD_EXM;
      operand = exm_result;
    end else if (hit_wb) begin
      sel     = FWD_WB;
      operand = wb_wdata;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline boundary. It latches the ID operands, the immediate and the
// decoded control. It detects a load-use hazard against the instruction in EX:
// in that case it stalls IF/ID and inserts one bubble. It also forwards
// EX/MEM and MEM/WB results onto the operands it latched.
// Ports:
//   clk, rst                          clock; asynchronous active-high reset
//   id_*                              instruction currently in ID
//   hold                              global freeze; every register keeps its value
//   flush                             taken branch/jump in EX; kill the ID instruction
//   exm_reg_write/waddr/result        EX/MEM forwarding source
//   wb_reg_write/waddr/wdata          MEM/WB forwarding source
//   stall_id                          combinational; hold PC and IF/ID this cycle
//   ex_*                              latched instruction fields seen by EX
//   ex_opa, ex_opb                    forwarded ALU operands
//   fwd_a, fwd_b                      forwarding selects (debug/coverage)
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [4:0]        id_waddr,
  input  logic [31:0]       id_rdata1,
  input  logic [31:0]       id_rdata2,
  input  logic [31:0]       id_imm,
  input  logic [31:0]       id_pc4,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              hold,
  input  logic              flush,
  input  logic              exm_reg_write,
  input  logic [4:0]        exm_waddr,
  input  logic [31:0]       exm_result,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_waddr,
  input  logic [31:0]       wb_wdata,
  output logic              stall_id,
  output logic              ex_valid,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic [4:0]        ex_waddr,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_pc4,
  output logic [31:0]       ex_opa,
  output logic [31:0]       ex_opb,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  id_ex_t            ex_q,   ex_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              luh;

  // A load in EX has no data yet. A dependent instruction in ID must wait one
  // cycle; after that the load data is taken from MEM/WB by forwarding.
  assign luh = ex_q.valid && ex_q.mem_read && (ex_q.waddr != REG_ZERO) && id_valid &&
               ((id_use_rs && (id_rs == ex_q.waddr)) ||
                (id_use_rt && (id_rt == ex_q.waddr)));

  // A flush kills the ID instruction anyway, so stalling for it is pointless.
  // During hold nothing advances, so the stall is suppressed as well.
  assign stall_id = luh && !flush && !hold;

  always_comb begin
    ex_d   = ex_q;
    ctrl_d = ctrl_q;
    if (flush || luh) begin
      ex_d   = '0;
      ctrl_d = '0;
    end else begin
      ex_d.valid     = id_valid;
      ex_d.mem_read  = id_mem_read  && id_valid;
      ex_d.mem_write = id_mem_write && id_valid;
      ex_d.reg_write = id_reg_write && id_valid;
      ex_d.waddr     = id_waddr;
      ex_d.rs        = id_rs;
      ex_d.rt        = id_rt;
      ex_d.rdata1    = id_rdata1;
      ex_d.rdata2    = id_rdata2;
      ex_d.imm       = id_imm;
      ex_d.pc4       = id_pc4;
      ctrl_d         = id_ctrl;
    end
  end

  // hold has priority over flush and bubbles: the register simply does not
  // load. EX keeps flush asserted while frozen, so a flush is not lost.
  // NOTE: sequential state uses non-blocking assignments, and the reset is in
  // the sensitivity list, so it clears the stage without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q   <= '0;
      ctrl_q <= '0;
    end else if (!hold) begin
      ex_q   <= ex_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_waddr     = ex_q.waddr;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_ctrl      = ctrl_q;
  assign ex_imm       = ex_q.imm;
  assign ex_pc4       = ex_q.pc4;

  fwd_unit u_fwd_a (
    .src_reg      (ex_q.rs),
    .rf_data      (ex_q.rdata1),
    .exm_reg_write(exm_reg_write),
    .exm_waddr    (exm_waddr),
    .exm_result   (exm_result),
    .wb_reg_write (wb_reg_write),
    .wb_waddr     (wb_waddr),
    .wb_wdata     (wb_wdata),
    .sel          (fwd_a),
    .operand      (ex_opa)
  );

  fwd_unit u_fwd_b (
    .src_reg      (ex_q.rt),
    .rf_data      (ex_q.rdata2),
    .exm_reg_write(exm_reg_write),
    .exm_waddr    (exm_waddr),
    .exm_result   (exm_result),
    .wb_reg_write (wb_reg_write),
    .wb_waddr     (wb_waddr),
    .wb_wdata     (wb_wdata),
    .sel          (fwd_b),
    .operand      (ex_opb)
  );

endmodule
